memory_arbiter: RTL and testbench

Single-port memory responder that services the instruction-fetch (iREN) and data (dREN/dWEN) requests the datapath raises from its control decode, and serialises them onto one RAM port. Sits between the datapath/request logic and the RAM model. Data requests take priority over fetches. Completion is signalled with one-cycle ihit/dhit pulses. A RAM fault or a stalled RAM latches a sticky error.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/arbiter_if.sv | 43 ++++
 rtl/memory_arbiter_wait_timer.sv | 29 ++
 rtl/memory_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: words, RAM handshake states and
// the memory arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    DREQ,
    IREQ,
    DONE,
    ERR
  } arb_state_t;

endpackage

// File: rtl/arbiter_if.sv
// Bundle of the arbiter request side and RAM side,
// with views for the arbiter, the datapath and the RAM.
interface arbiter_if;
  import cpu_types_pkg::*;

  logic      halt;
  logic      iREN;
  word_t     iaddr;
  logic      ihit;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      merr;

  modport arb (
    input  halt, iREN, iaddr, dREN, dWEN,
    input  daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, merr,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport dp (
    output halt, iREN, iaddr, dREN, dWEN,
    output daddr, dstore,
    input  ihit, iload, dhit, dload, merr
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/memory_arbiter_wait_timer.sv
// Saturating wait counter for one RAM access;
// expired flags the last allowed wait cycle.
module wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // count wait cycles, holding at the last value
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Serialises data and fetch requests onto one RAM
// port; data wins, errors and timeouts are sticky.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  arb_state_t state;
  arb_state_t next;
  word_t      addr_q;
  word_t      wdata_q;
  word_t      iload_q;
  word_t      dload_q;
  logic       wr_q;
  logic       data_q;
  logic       busy;
  logic       held;
  logic       expired;
  logic       dreq;
  logic       ireq;
  ramstate_t  rs;

  assign rs   = ramstate_t'(ramstate);
  assign busy = (state == DREQ) || (state == IREQ);
  assign dreq = dREN | dWEN;
  assign ireq = iREN & ~halt;
  assign held = (state == DREQ) ? dreq : iREN;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (~busy),
    .enable (busy),
    .expired(expired)
  );

  // next state: ACCESS beats error/timeout beats abort
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (dreq)      next = DREQ;
        else if (ireq) next = IREQ;
      end
      DREQ, IREQ: begin
        if (rs == ACCESS)
          next = DONE;
        else if (rs == ERROR || expired)
          next = ERR;
        else if (!held)
          next = IDLE;
      end
      DONE:    next = IDLE;
      ERR:     next = ERR;
      default: next = IDLE;
    endcase
  end

  // state, request latches and load registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state <= next;
      if (state == IDLE) begin
        if (dreq) begin
          addr_q  <= daddr;
          wdata_q <= dstore;
          wr_q    <= dWEN;
          data_q  <= 1'b1;
        end else if (ireq) begin
          addr_q <= iaddr;
          wr_q   <= 1'b0;
          data_q <= 1'b0;
        end
      end
      if (busy && rs == ACCESS) begin
        if (data_q) dload_q <= ramload;
        else        iload_q <= ramload;
      end
    end
  end

  assign ramREN   = busy & ~wr_q;
  assign ramWEN   = (state == DREQ) & wr_q;
  assign ramaddr  = busy ? {addr_q[31:2], 2'b00} : '0;
  assign ramstore = ramWEN ? wdata_q : '0;
  assign ihit     = (state == DONE) & ~data_q;
  assign dhit     = (state == DONE) & data_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign merr     = (state == ERR);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a
// transaction-level reference model checked every cycle.
module tb_memory_arbiter;

  localparam int TO = 8;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        halt = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = RS_FREE;
  logic        merr;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 0;

  memory_arbiter #(
    .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .merr(merr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: phase 0 waiting, 1 accessing RAM,
  // 2 reporting completion, 3 stuck in error.
  int          m_phase = 0;
  bit          m_data = 0;
  bit          m_wr = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          m_waited = 0;
  logic [31:0] m_iload = '0;
  logic [31:0] m_dload = '0;

  always @(posedge CLK) begin
    if (RST) begin
      m_phase = 0; m_data = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_waited = 0;
      m_iload = '0; m_dload = '0;
    end else if (m_phase == 0) begin
      if (dREN || dWEN) begin
        m_phase = 1; m_data = 1; m_wr = dWEN;
        m_addr = daddr; m_wdata = dstore; m_waited = 0;
      end else if (iREN && !halt) begin
        m_phase = 1; m_data = 0; m_wr = 0;
        m_addr = iaddr; m_waited = 0;
      end
    end else if (m_phase == 1) begin
      m_waited = m_waited + 1;
      if (ramstate == RS_ACCESS) begin
        if (m_data) m_dload = ramload;
        else        m_iload = ramload;
        m_phase = 2;
      end else if (ramstate == RS_ERROR || m_waited >= TO) begin
        m_phase = 3;
      end else if (m_data ? !(dREN || dWEN) : !iREN) begin
        m_phase = 0;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  end

  // compare every DUT output to the model each cycle
  always @(negedge CLK) begin
    if (started) begin
      automatic bit act = (m_phase == 1);
      automatic bit wr = act && m_data && m_wr;
      chk("ramREN", 32'(ramREN), 32'(act && !wr));
      chk("ramWEN", 32'(ramWEN), 32'(wr));
      chk("ramaddr", ramaddr, act ? {m_addr[31:2], 2'b00} : 32'h0);
      chk("ramstore", ramstore, wr ? m_wdata : 32'h0);
      chk("ihit", 32'(ihit), 32'(m_phase == 2 && !m_data));
      chk("dhit", 32'(dhit), 32'(m_phase == 2 && m_data));
      chk("iload", iload, m_iload);
      chk("dload", dload, m_dload);
      chk("merr", 32'(merr), 32'(m_phase == 3));
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, ".ihit"}, 32'(ihit), 0);
    chk({nm, ".dhit"}, 32'(dhit), 0);
    chk({nm, ".iload"}, iload, 0);
    chk({nm, ".dload"}, dload, 0);
    chk({nm, ".ramREN"}, 32'(ramREN), 0);
    chk({nm, ".ramWEN"}, 32'(ramWEN), 0);
    chk({nm, ".ramaddr"}, ramaddr, 0);
    chk({nm, ".ramstore"}, ramstore, 0);
    chk({nm, ".merr"}, 32'(merr), 0);
  endtask

  initial begin
    tick();
    tick();
    started = 1;
    chk_all_zero("reset");
    RST = 0;

    // zero-wait fetch
    iREN = 1; iaddr = 32'h44;
    ramstate = RS_ACCESS; ramload = 32'h3C01_1234;
    tick();
    chk("t1.ramREN", 32'(ramREN), 1);
    chk("t1.ramaddr", ramaddr, 32'h44);
    tick();
    chk("t1.ihit", 32'(ihit), 1);
    chk("t1.iload", iload, 32'h3C01_1234);
    iREN = 0; ramstate = RS_FREE;
    tick();
    chk("t1.ihit_once", 32'(ihit), 0);

    // write beats fetch, misaligned address, 3 busy cycles
    iREN = 1; iaddr = 32'h48;
    dWEN = 1; daddr = 32'h102; dstore = 32'hDEAD_BEEF;
    ramstate = RS_BUSY;
    tick();
    chk("t2.ramWEN", 32'(ramWEN), 1);
    chk("t2.ramREN", 32'(ramREN), 0);
    chk("t2.ramaddr", ramaddr, 32'h100);
    chk("t2.ramstore", ramstore, 32'hDEAD_BEEF);
    tick();
    tick();
    tick();
    ramstate = RS_ACCESS;
    tick();
    chk("t2.dhit", 32'(dhit), 1);
    chk("t2.ihit", 32'(ihit), 0);
    dWEN = 0; ramstate = RS_FREE;
    tick();
    chk("t2.idle_gap", 32'(ramREN), 0);
    ramstate = RS_ACCESS; ramload = 32'h1111_2222;
    tick();
    chk("t2.f_ramREN", 32'(ramREN), 1);
    chk("t2.f_ramaddr", ramaddr, 32'h48);
    tick();
    chk("t2.f_ihit", 32'(ihit), 1);
    chk("t2.f_iload", iload, 32'h1111_2222);
    iREN = 0; ramstate = RS_FREE;
    tick();

    // halt blocks fetches but not data
    halt = 1; iREN = 1; iaddr = 32'h60;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3.halted", 32'(ramREN), 0);
    end
    dREN = 1; daddr = 32'h200;
    ramstate = RS_ACCESS; ramload = 32'hCAFE_0001;
    tick();
    chk("t3.d_ramREN", 32'(ramREN), 1);
    chk("t3.d_ramaddr", ramaddr, 32'h200);
    tick();
    chk("t3.dhit", 32'(dhit), 1);
    chk("t3.dload", dload, 32'hCAFE_0001);
    dREN = 0; ramstate = RS_FREE;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3.halted2", 32'(ramREN), 0);
    end
    halt = 0; iREN = 0;
    tick();

    // abort by dropping dREN
    dREN = 1; daddr = 32'h300; ramstate = RS_BUSY;
    tick();
    chk("t4.ramREN", 32'(ramREN), 1);
    tick();
    dREN = 0;
    tick();
    chk("t4.aborted", 32'(ramREN), 0);
    chk("t4.no_dhit", 32'(dhit), 0);
    tick();
    chk("t4.no_dhit2", 32'(dhit), 0);

    // reset in the middle of a write
    dWEN = 1; daddr = 32'h304; dstore = 32'h55;
    tick();
    chk("t5.ramWEN", 32'(ramWEN), 1);
    RST = 1;
    tick();
    chk_all_zero("t5");
    RST = 0; dWEN = 0; ramstate = RS_FREE;
    tick();

    // RAM error during a fetch
    iREN = 1; iaddr = 32'h80; ramstate = RS_BUSY;
    tick();
    chk("t6.ramREN", 32'(ramREN), 1);
    ramstate = RS_ERROR;
    tick();
    chk("t6.merr", 32'(merr), 1);
    chk("t6.no_ihit", 32'(ihit), 0);
    iREN = 0; ramstate = RS_FREE; dREN = 1;
    tick();
    tick();
    chk("t6.sticky", 32'(merr), 1);
    chk("t6.no_grant", 32'(ramREN), 0);
    RST = 1; dREN = 0;
    tick();
    RST = 0;
    tick();
    chk("t6.cleared", 32'(merr), 0);

    // timeout after TO wait cycles
    dREN = 1; daddr = 32'h400; ramstate = RS_BUSY;
    repeat (TO) tick();
    chk("t7.last_wait", 32'(merr), 0);
    chk("t7.still_rd", 32'(ramREN), 1);
    tick();
    chk("t7.merr", 32'(merr), 1);
    iREN = 1;
    repeat (3) tick();
    chk("t7.sticky", 32'(merr), 1);
    RST = 1; dREN = 0; iREN = 0;
    tick();
    RST = 0;
    tick();

    // ACCESS on the last allowed cycle wins over timeout
    dREN = 1; daddr = 32'h404; ramstate = RS_BUSY;
    ramload = 32'h0BAD_F00D;
    repeat (TO) tick();
    ramstate = RS_ACCESS;
    tick();
    chk("t8.dhit", 32'(dhit), 1);
    chk("t8.merr", 32'(merr), 0);
    chk("t8.dload", dload, 32'h0BAD_F00D);
    dREN = 0; ramstate = RS_FREE;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
